fft_frame_player: RTL and testbench
===================================

# fft_frame_player

Output-side counterpart of the microphone-to-FFT capture path: accepts 64-point frames streamed one sample per `in_en` cycle (the FFT/IFFT output interface, bit-reversed index order), restores natural order, and plays each frame to the 16-bit `sound` output at a fixed decimated rate. Two 64-entry banks (ping-pong) let one frame load while the other plays. Sits between the transform core's `do_en`/`do_re` outputs and the board's `sound` port in `lab_top`.

## Interface

- `width`, 16, sample width of `in_re` and `sound`
- `sample_div`, 12, clocks per output sample (≥2); matches the capture-side decimation
- `bit_reversed`, 1, 1: incoming index k is stored at address bitrev6(k); 0: stored at k

- `clk`  in  1  single clock for all logic
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_en`  in  1  input sample valid (one sample per high cycle)
- `in_re`  in  width  input sample (real part; imaginary part not consumed)
- `in_ready`  out  1  write bank free; `in_en` is accepted only while high
- `clear_flags`  in  1  synchronous clear of `underrun` and `overflow`
- `sound`  out  width  registered playback sample
- `frame_start`  out  1  one-cycle pulse on the cycle sample 0 of a frame is output
- `playing`  out  1  high while in PLAY
- `underrun`  out  1  sticky: playback finished a frame with no next frame ready
- `overflow`  out  1  sticky: `in_en` seen while `in_ready` low

## Operation

- Storage: `bank[2][64]` of `width` bits; `full[1:0]`; write pointer `wr_bank`, `wr_cnt[5:0]`; read pointer `rd_bank`, `rd_cnt[5:0]`.
- Write side: `in_ready = !full[wr_bank]`. On `in_en && in_ready`: `bank[wr_bank][addr] <= in_re`, addr = bitrev6(wr_cnt) if `bit_reversed`, else wr_cnt; `wr_cnt++`. When `wr_cnt==63` is accepted: `full[wr_bank] <= 1`, `wr_bank` toggles, `wr_cnt` wraps to 0. Gaps between `in_en` pulses allowed; a frame is any 64 accepted samples.
- `in_en && !in_ready`: sample dropped, `overflow <= 1`, no pointer change.
- Divider: free-running `div_cnt` 0..sample_div-1; `tick` = (div_cnt == sample_div-1).
- FSM, IDLE:
  - on `tick` with `full[rd_bank]`: `sound <= bank[rd_bank][0]`, `rd_cnt <= 1`, `frame_start` pulses, go to PLAY.
  - on `tick` otherwise: `sound <= 0`.
- FSM, PLAY:
  - on `tick` with rd_cnt 1..63: `sound <= bank[rd_bank][rd_cnt]`, `rd_cnt++`.
  - The tick that follows output of sample 63 releases the bank: `full[rd_bank] <= 0`, `rd_bank` toggles.
    - If the other bank is full, output its sample 0 on that same tick, pulse `frame_start`, stay in PLAY (gapless).
    - Otherwise `underrun <= 1`, `sound <= 0`, go to IDLE.
- Release vs. write completion in the same cycle: both take effect, since they always target different banks. `in_ready` reflects the registered `full` bits, so a just-released bank is writable from the next cycle.
- `clear_flags` clears both sticky flags. If a set event occurs in the same cycle, the set wins.
- `width` arithmetic: none. Samples pass unmodified.

## Timing

- Reset (`rst_n` low, any time): `sound`=0, `frame_start`=0, `playing`=0, `underrun`=0, `overflow`=0, `in_ready`=1. All pointers, counters and `div_cnt` are 0, `full`=00, FSM is IDLE. Any partial or buffered frames are discarded.
- Write acceptance takes 1 cycle. A frame becomes `full` on the edge that accepts its 64th sample.
- Start latency: sample 0 appears on the first `tick` edge strictly after the full edge. This is 1..sample_div cycles.
- Playback: one sample per `sample_div` cycles. A frame occupies 64·sample_div cycles of `sound`.
- `frame_start` is coincident with the `sound` update for sample 0.
- Steady-state throughput: sustained if each new frame completes before the playing frame's last sample is consumed.

## Test plan

- Reset, then feed 64 samples with `in_re`=k (k=0..63), `bit_reversed`=1, `sample_div`=12 → `sound` sequence 0,32,16,48,8,40,…,63 (bitrev order), one value per 12 clocks; `frame_start` pulses once; then `underrun`=1 and `sound`=0.
- Same stimulus with `bit_reversed`=0 → `sound` = 0,1,2,…,63.
- Load frame A (values 0x1000+k), then frame B (0x2000+k) during A's playback → B sample 0 follows A sample 63 exactly 12 clocks later; `underrun` stays 0; two `frame_start` pulses.
- Load two frames, then assert `in_en` with a third value → `in_ready`=0, `overflow`=1, and playback of A then B is unaffected. Pulse `clear_flags` → `overflow`=0.
- Drop `rst_n` mid-frame during PLAY, at rd_cnt=30 → all outputs take reset values asynchronously; after release, `in_ready`=1, `sound` stays 0 until a new full frame is loaded.
- Feed a frame with 5-cycle gaps between `in_en` pulses → playback identical to the gapless case.

Source files
------------

// File: rtl/fft_frame_player_if.sv
// Sample stream from the transform core into the frame player.
// Ports: in_en (sample valid), in_re (real sample), in_ready (write bank free).
// Latency: none, wires only. Backpressure: the source must hold in_en low while in_ready is low.
interface fft_frame_player_if #(
  parameter int width = 16
);
  logic             in_en;
  logic [width-1:0] in_re;
  logic             in_ready;

  modport master (output in_en, output in_re, input in_ready);
  modport slave  (input in_en, input in_re, output in_ready);
endinterface

// File: rtl/fft_frame_player.sv
// Ping-pong frame player: loads 64-point frames, restores natural order, plays them to sound.
// Latency: 1 cycle write acceptance; sample 0 appears on the first tick after the frame is full.
// Backpressure: in_ready low while the write bank is still full; samples offered then are dropped and flagged.
// Ports: clk, rst_n (async active-low), in_bus (in_en/in_re/in_ready), clear_flags,
//        sound (registered sample), frame_start, playing, underrun, overflow.
module fft_frame_player #(
  parameter int width        = 16,
  parameter int sample_div   = 12,
  parameter bit bit_reversed = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_frame_player_if.slave     in_bus,
  input  logic                  clear_flags,
  output logic [width-1:0]      sound,
  output logic                  frame_start,
  output logic                  playing,
  output logic                  underrun,
  output logic                  overflow
);

  localparam int dw = (sample_div > 1) ? $clog2(sample_div) : 1;

  typedef enum logic {IDLE, PLAY} state_t;

  logic [width-1:0] bank [2][64];
  logic [1:0]       full;
  logic             wr_bank;
  logic [5:0]       wr_cnt;
  logic             rd_bank;
  logic [5:0]       rd_cnt;
  logic [dw-1:0]    div_cnt;
  state_t           state;

  logic             in_ready_i;
  logic             accept;
  logic             tick;
  logic [5:0]       wr_addr;

  function automatic logic [5:0] bitrev6(input logic [5:0] a);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = a[5-i];
    return r;
  endfunction

  assign in_ready_i      = !full[wr_bank];
  assign in_bus.in_ready = in_ready_i;
  assign accept          = in_bus.in_en && in_ready_i;
  assign tick            = (div_cnt == dw'(sample_div - 1));
  assign wr_addr         = bit_reversed ? bitrev6(wr_cnt) : wr_cnt;

  // Sample storage carries no reset: clearing full[] is what discards frames.
  always_ff @(posedge clk) begin
    if (accept) bank[wr_bank][wr_addr] <= in_bus.in_re;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full        <= 2'b00;
      wr_bank     <= 1'b0;
      wr_cnt      <= 6'd0;
      rd_bank     <= 1'b0;
      rd_cnt      <= 6'd0;
      div_cnt     <= '0;
      state       <= IDLE;
      sound       <= '0;
      frame_start <= 1'b0;
      playing     <= 1'b0;
      underrun    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      div_cnt     <= tick ? '0 : div_cnt + 1'b1;

      // Clear first so that a set event in the same cycle takes precedence.
      if (clear_flags) begin
        underrun <= 1'b0;
        overflow <= 1'b0;
      end

      if (in_bus.in_en) begin
        if (in_ready_i) begin
          wr_cnt <= wr_cnt + 6'd1;
          if (wr_cnt == 6'd63) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
          end
        end else begin
          overflow <= 1'b1;
        end
      end

      // The write side only ever sets the bank it owns (which is empty), and the
      // read side only clears the bank it plays (which is full), so the two
      // full[] updates below never collide with the one above.
      if (tick) begin
        case (state)
          IDLE: begin
            if (full[rd_bank]) begin
              sound       <= bank[rd_bank][0];
              rd_cnt      <= 6'd1;
              frame_start <= 1'b1;
              playing     <= 1'b1;
              state       <= PLAY;
            end else begin
              sound <= '0;
            end
          end
          PLAY: begin
            // rd_cnt wraps to 0 after sample 63, so 0 here means "frame done".
            if (rd_cnt != 6'd0) begin
              sound  <= bank[rd_bank][rd_cnt];
              rd_cnt <= rd_cnt + 6'd1;
            end else begin
              full[rd_bank] <= 1'b0;
              rd_bank       <= ~rd_bank;
              if (full[~rd_bank]) begin
                sound       <= bank[~rd_bank][0];
                rd_cnt      <= 6'd1;
                frame_start <= 1'b1;
              end else begin
                underrun <= 1'b1;
                sound    <= '0;
                playing  <= 1'b0;
                state    <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_player.sv
// Bench for fft_frame_player: one instance with bit-reversed storage, one with natural order,
// both fed the same stream, checked against a hand-written bit-reversal table.
module tb_fft_frame_player;

  localparam int W   = 16;
  localparam int DIV = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         clear_flags = 1'b0;
  logic         in_en = 1'b0;
  logic [W-1:0] in_re = '0;

  logic [W-1:0] sound_r, sound_n;
  logic         fs_r, fs_n, playing_r, playing_n, underrun_r, underrun_n, overflow_r, overflow_n;

  fft_frame_player_if #(.width(W)) bus_r ();
  fft_frame_player_if #(.width(W)) bus_n ();

  assign bus_r.in_en = in_en;
  assign bus_r.in_re = in_re;
  assign bus_n.in_en = in_en;
  assign bus_n.in_re = in_re;

  fft_frame_player #(.width(W), .sample_div(DIV), .bit_reversed(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_bus(bus_r.slave), .clear_flags(clear_flags),
    .sound(sound_r), .frame_start(fs_r), .playing(playing_r),
    .underrun(underrun_r), .overflow(overflow_r));

  fft_frame_player #(.width(W), .sample_div(DIV), .bit_reversed(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_bus(bus_n.slave), .clear_flags(clear_flags),
    .sound(sound_n), .frame_start(fs_n), .playing(playing_n),
    .underrun(underrun_n), .overflow(overflow_n));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] in_val;
    logic [15:0] exp_rev;
    logic [15:0] exp_nat;
  } vec_t;

  vec_t tab[64];
  int   rev_lut[64] = '{
     0, 32, 16, 48,  8, 40, 24, 56,  4, 36, 20, 52, 12, 44, 28, 60,
     2, 34, 18, 50, 10, 42, 26, 58,  6, 38, 22, 54, 14, 46, 30, 62,
     1, 33, 17, 49,  9, 41, 25, 57,  5, 37, 21, 53, 13, 45, 29, 61,
     3, 35, 19, 51, 11, 43, 27, 59,  7, 39, 23, 55, 15, 47, 31, 63};

  int checks = 0;
  int errors = 0;
  int fs_count = 0;

  always @(negedge clk) if (fs_r === 1'b1) fs_count++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_frame(input logic [15:0] base, input int gap);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      in_en = 1'b1;
      in_re = base + tab[k].in_val;
      if (gap > 0) begin
        @(negedge clk);
        in_en = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    in_en = 1'b0;
  endtask

  task automatic wait_fs(input string name);
    int t;
    @(negedge clk);
    t = 0;
    while (fs_r !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s: frame_start timeout got none expected pulse", name);
    end
  endtask

  task automatic play_frames(input int nframes, input logic [15:0] base0, input logic [15:0] base1);
    logic [15:0] base;
    wait_fs("play_start");
    for (int f = 0; f < nframes; f++) begin
      base = (f == 0) ? base0 : base1;
      for (int j = 0; j < 64; j++) begin
        if (!(f == 0 && j == 0)) begin
          repeat (DIV) @(posedge clk);
          @(negedge clk);
        end
        chk($sformatf("sound_rev f%0d s%0d", f, j), sound_r, base + tab[j].exp_rev);
        chk($sformatf("sound_nat f%0d s%0d", f, j), sound_n, base + tab[j].exp_nat);
        if (j == 0) begin
          chk($sformatf("frame_start_r f%0d", f), fs_r, 1);
          chk($sformatf("frame_start_n f%0d", f), fs_n, 1);
          chk($sformatf("playing f%0d", f), playing_r, 1);
          chk($sformatf("underrun_gapless f%0d", f), underrun_r, 0);
        end
        if (j == 1) chk($sformatf("frame_start_low f%0d", f), fs_r, 0);
      end
    end
    repeat (DIV) @(posedge clk);
    @(negedge clk);
    chk("underrun_r_end", underrun_r, 1);
    chk("underrun_n_end", underrun_n, 1);
    chk("sound_r_end", sound_r, 0);
    chk("sound_n_end", sound_n, 0);
    chk("playing_end", playing_r, 0);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation got stuck expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs0;
    int bad;

    for (int k = 0; k < 64; k++) begin
      tab[k].in_val  = 16'(k);
      tab[k].exp_rev = 16'(rev_lut[k]);
      tab[k].exp_nat = 16'(k);
    end

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sound", sound_r, 0);
    chk("rst_frame_start", fs_r, 0);
    chk("rst_playing", playing_r, 0);
    chk("rst_underrun", underrun_r, 0);
    chk("rst_overflow", overflow_r, 0);
    chk("rst_in_ready", bus_r.in_ready, 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single frame, both storage orders, ends in underrun
    fs0 = fs_count;
    fork
      load_frame(16'h0000, 0);
      play_frames(1, 16'h0000, 16'h0000);
    join
    chk("fs_count_single", fs_count - fs0, 1);

    @(negedge clk) clear_flags = 1'b1;
    @(negedge clk) clear_flags = 1'b0;
    chk("clear_underrun_r", underrun_r, 0);
    chk("clear_underrun_n", underrun_n, 0);

    // Two frames back to back, overflow attempt, gapless playback
    fs0 = fs_count;
    fork
      begin
        load_frame(16'h1000, 0);
        load_frame(16'h2000, 0);
        @(negedge clk);
        chk("in_ready_r_both_full", bus_r.in_ready, 0);
        chk("in_ready_n_both_full", bus_n.in_ready, 0);
        in_en = 1'b1;
        in_re = 16'hdead;
        @(negedge clk);
        in_en = 1'b0;
        chk("overflow_r_set", overflow_r, 1);
        chk("overflow_n_set", overflow_n, 1);
        clear_flags = 1'b1;
        in_en = 1'b1;
        @(negedge clk);
        in_en = 1'b0;
        chk("overflow_set_beats_clear", overflow_r, 1);
        @(negedge clk);
        clear_flags = 1'b0;
        chk("overflow_cleared", overflow_r, 0);
        chk("underrun_still_clear", underrun_r, 0);
      end
      play_frames(2, 16'h1000, 16'h2000);
    join
    chk("fs_count_gapless", fs_count - fs0, 2);

    // Asynchronous reset in the middle of playback
    load_frame(16'h4000, 0);
    wait_fs("reset_test_start");
    repeat (29 * DIV) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_sample29", sound_r, 16'h4000 + tab[29].exp_rev);
    chk("pre_reset_playing", playing_r, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sound_r", sound_r, 0);
    chk("async_rst_sound_n", sound_n, 0);
    chk("async_rst_playing", playing_r, 0);
    chk("async_rst_frame_start", fs_r, 0);
    chk("async_rst_underrun", underrun_r, 0);
    chk("async_rst_overflow", overflow_r, 0);
    chk("async_rst_in_ready", bus_r.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus_r.in_ready, 1);
    fs0 = fs_count;
    bad = 0;
    repeat (800) begin
      @(negedge clk);
      if (sound_r !== '0 || sound_n !== '0 || playing_r !== 1'b0) bad++;
    end
    chk("post_rst_silent_cycles", bad, 0);
    chk("post_rst_no_frame_start", fs_count - fs0, 0);

    // Gapped input stream plays identically
    fork
      load_frame(16'h5000, 5);
      play_frames(1, 16'h5000, 16'h5000);
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
